// File: rtl/sprinkler_scheduler_if.sv
// Handshake bundle between the sprinkler sequencer and its controller.
// Master drives requests; slave (the scheduler) drives the decoder lines.
interface sprinkler_scheduler_if #(
  parameter int DUR_W = 16
);
  logic             start;
  logic             abort;
  logic [7:0]       zone_mask;
  logic [DUR_W-1:0] duration;
  logic             valve_en;
  logic [2:0]       zone;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output abort,
    output zone_mask,
    output duration,
    input  valve_en,
    input  zone,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  zone_mask,
    input  duration,
    output valve_en,
    output zone,
    output busy,
    output done
  );
endinterface

// File: rtl/sprinkler_scheduler.sv
// Zone sequencer for a 3-to-8 valve decoder: waters each selected zone
// for a fixed duration in ascending order, with an all-off gap after each.
module sprinkler_scheduler #(
  parameter int DUR_W      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprinkler_scheduler_if.slave bus
);

  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_WATER = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [7:0]       r_rem;
  logic [DUR_W-1:0] r_dur;
  logic [DUR_W-1:0] r_cnt;
  logic [GW-1:0]    r_gcnt;
  logic             r_valve;
  logic [2:0]       r_zone;

  logic [2:0]       w_low_idx;
  logic [7:0]       w_rem_next;
  logic             w_accept;

  always_comb begin
    w_low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r_rem[i]) w_low_idx = 3'(i);
    end
  end

  // clears the lowest set bit
  assign w_rem_next = r_rem & (r_rem - 8'd1);
  assign w_accept   = (bus.zone_mask != 8'd0) &&
                      (bus.duration != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_dur   <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_valve <= 1'b0;
      r_zone  <= '0;
    end else if (r_state != S_IDLE && bus.abort) begin
      r_state <= S_IDLE;
      r_valve <= 1'b0;
      r_rem   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_accept) begin
              r_rem   <= bus.zone_mask;
              r_dur   <= bus.duration;
              r_state <= S_SCAN;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SCAN: begin
          if (r_rem == 8'd0) begin
            r_state <= S_DONE;
          end else begin
            r_zone  <= w_low_idx;
            r_rem   <= w_rem_next;
            r_cnt   <= r_dur;
            r_valve <= 1'b1;
            r_state <= S_WATER;
          end
        end
        S_WATER: begin
          r_cnt <= r_cnt - DUR_W'(1);
          if (r_cnt == DUR_W'(1)) begin
            r_valve <= 1'b0;
            if (GAP_CYCLES > 0) begin
              r_gcnt  <= GAP_LD;
              r_state <= S_GAP;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_GAP: begin
          r_gcnt <= r_gcnt - GW'(1);
          if (r_gcnt == GW'(1)) r_state <= S_SCAN;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valve <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valve_en = r_valve;
  assign bus.zone     = r_zone;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);

endmodule

// File: doc/sprinkler_scheduler.md
# sprinkler_scheduler

Sequencing controller for the 3-to-8 sprinkler valve decoder. It steps through a programmable subset of the eight zones and drives the decoder's enable and select lines (E, A, B, C) from registered outputs. Each selected zone is watered for a fixed number of clock cycles, followed by an all-valves-off gap. Exactly one valve is open at any time, and never during a gap.

## Interface

Parameters:
- DUR_W, 16: width of the per-zone watering duration in cycles.
- GAP_CYCLES, 4: all-off cycles inserted after every watered zone. A value of 0 means no gap.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a watering cycle. Sampled in IDLE only.
- abort  in  1  terminate the current cycle immediately. Sampled in every state except IDLE.
- zone_mask  in  8  bit i set means zone i is watered. Latched on an accepted start.
- duration  in  DUR_W  cycles per zone. Latched on an accepted start.
- valve_en  out  1  decoder enable E; high means a valve is open.
- zone  out  3  decoder select, with zone[2]=A, zone[1]=B, zone[0]=C.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a cycle completes or is rejected.

## Operation

- Reset values: state=IDLE, valve_en=0, zone=0, busy=0, done=0, internal mask/counters=0.
- States and transitions:
  - IDLE:
    - start=1 with zone_mask!=0 and duration!=0: latch rem_mask<=zone_mask and dur_q<=duration, then go to SCAN.
    - start=1 with zone_mask==0 or duration==0: go to DONE. This is a rejected request, and done still pulses.
  - SCAN:
    - rem_mask==0: go to DONE.
    - Otherwise: zone<=index of the lowest set bit of rem_mask, clear that bit, cnt<=dur_q, valve_en<=1, go to WATER.
  - WATER:
    - cnt decrements each cycle.
    - When cnt==1: valve_en<=0. Then, if GAP_CYCLES>0, go to GAP with gcnt<=GAP_CYCLES; otherwise go to SCAN.
  - GAP:
    - gcnt decrements. When gcnt==1, go to SCAN.
  - DONE:
    - done=1 for this single cycle, then go to IDLE.
- abort has priority over every other transition in SCAN, WATER, GAP and DONE:
  - Next state is IDLE, with valve_en<=0 and rem_mask<=0.
  - done is not pulsed.
  - abort in IDLE is ignored.
- start is ignored when not in IDLE. Changes to zone_mask or duration while busy have no effect.
- zone is updated only in SCAN. It holds the last watered zone through GAP, DONE and IDLE.
- Zones are always visited in ascending index order, once each per cycle.
- Counter widths: cnt is DUR_W bits. gcnt is $clog2(GAP_CYCLES+1) bits, minimum 1.
- The all-ones duration (2^DUR_W−1) is legal. There is no wrap, because the counter only decrements from a nonzero load.
- Invariant: valve_en=1 only in WATER, and zone is stable whenever valve_en=1.

## Timing

- All outputs are registered; none has a combinational path from an input.
- start accepted at edge k: SCAN occupies cycle k+1, and valve_en rises at edge k+2.
- valve_en is high for exactly dur_q consecutive cycles per zone.
- Zone-to-zone spacing: the valve is low for GAP_CYCLES+1 cycles (gap plus SCAN) between consecutive zones.
- Trailing sequence: a gap follows the last zone too, then SCAN (empty mask), then DONE.
- Total busy cycles: N·(dur_q + GAP_CYCLES + 1) + 2, where N = popcount(zone_mask).
- Rejected start: busy and done are both high for one cycle (DONE), at edge k+1.
- abort sampled at edge j: valve_en=0 and busy=0 from edge j+1.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously), independent of clk.

## Test plan

- Reset while valve_en=1 in WATER:
  - During reset: valve_en=0, zone=0, busy=0, done=0 without waiting for a clock edge.
  - After release: stays IDLE until start.
- Basic sequence: zone_mask=8'b1010_0001, duration=3, GAP_CYCLES=4, start at edge 0.
  - valve_en high cycles 2–4 (zone=0), 10–12 (zone=5), 18–20 (zone=7).
  - done pulses in cycle 26.
  - busy is high cycles 1–26.
- Rejection: start with zone_mask=0, then start with duration=0.
  - Each gives busy=1 and done=1 for exactly one cycle.
  - valve_en never rises.
- Abort: mask=8'hFF, duration=10, abort asserted in the 5th WATER cycle of zone 2.
  - valve_en=0 at the next edge, busy=0, no done pulse.
  - A following start begins again at zone 0.
- Ignored inputs while busy: re-pulse start and change zone_mask/duration mid-cycle.
  - Sequence and timing are identical to the unperturbed run.
- Boundaries:
  - GAP_CYCLES=0, mask=8'h80, duration=1: valve_en high 1 cycle with zone=7; done in cycle 4.
  - duration=16'hFFFF on a single zone: valve_en high for 65535 cycles.
